// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I controller: steps FETCH/DECODE/EXECUTE/MEM/WB, gates decoder
// write enables into the correct cycle, traps on illegal opcodes and memory timeouts.
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             dec_reg_we,
  input  logic             dec_ram_we,
  input  logic             dec_br_en,
  input  logic             br_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             ram_we,
  output logic             reg_we,
  output logic             pc_enable,
  output logic             pc_sel_branch,
  output logic [2:0]       state,
  output logic             illegal_op,
  output logic             bus_timeout,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_MEM     = 3'd4;
  localparam logic [2:0] S_WB      = 3'd5;
  localparam logic [2:0] S_TRAP    = 3'd7;

  localparam logic [1:0] C_ALU    = 2'd0;
  localparam logic [1:0] C_LOAD   = 2'd1;
  localparam logic [1:0] C_STORE  = 2'd2;
  localparam logic [1:0] C_BRANCH = 2'd3;

  // Returns {legal, class} for an opcode.
  function automatic logic [2:0] classify(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011: classify = {1'b1, C_ALU};
      7'b0000011:             classify = {1'b1, C_LOAD};
      7'b0100011:             classify = {1'b1, C_STORE};
      7'b1100011:             classify = {1'b1, C_BRANCH};
      default:                classify = {1'b0, C_ALU};
    endcase
  endfunction

  logic [2:0]        cur_state;
  logic [2:0]        nxt_state;
  logic [2:0]        op_info;
  logic [1:0]        cls;
  logic              reg_we_lat;
  logic              ram_we_lat;
  logic              br_en_lat;
  logic [WAIT_W-1:0] wait_cnt;
  logic              fetch_expire;
  logic              mem_expire;
  logic [CNT_W-1:0]  retired_cnt;
  logic              illegal_r;
  logic              timeout_r;

  assign op_info      = classify(opcode);
  assign fetch_expire = (cur_state == S_FETCH) && !imem_ready && (wait_cnt == WAIT_LAST);
  assign mem_expire   = (cur_state == S_MEM) && !dmem_ready && (wait_cnt == WAIT_LAST);

  assign state       = cur_state;
  assign retired     = retired_cnt;
  assign illegal_op  = illegal_r;
  assign bus_timeout = timeout_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic; a ready seen in the final wait cycle beats the timeout.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:   nxt_state = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          nxt_state = S_DECODE;
        end else if (fetch_expire) begin
          nxt_state = S_TRAP;
        end else begin
          nxt_state = S_FETCH;
        end
      end
      S_DECODE: begin
        if (op_info[2]) begin
          nxt_state = S_EXECUTE;
        end else begin
          nxt_state = S_TRAP;
        end
      end
      S_EXECUTE: begin
        case (cls)
          C_BRANCH:         nxt_state = S_FETCH;
          C_LOAD, C_STORE:  nxt_state = S_MEM;
          default:          nxt_state = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (cls == C_STORE) begin
            nxt_state = S_FETCH;
          end else begin
            nxt_state = S_WB;
          end
        end else if (mem_expire) begin
          nxt_state = S_TRAP;
        end else begin
          nxt_state = S_MEM;
        end
      end
      S_WB:     nxt_state = S_FETCH;
      S_TRAP:   nxt_state = S_TRAP;
      default:  nxt_state = S_TRAP;
    endcase
  end

  // Output decode; enables are forced low in every state not listed.
  always_comb begin
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    dmem_req      = 1'b0;
    ram_we        = 1'b0;
    reg_we        = 1'b0;
    pc_enable     = 1'b0;
    pc_sel_branch = 1'b0;
    case (cur_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      S_EXECUTE: begin
        if (cls == C_BRANCH) begin
          pc_enable     = 1'b1;
          pc_sel_branch = br_taken & br_en_lat;
        end else begin
          pc_enable     = 1'b0;
        end
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        ram_we    = ram_we_lat;
        pc_enable = dmem_ready && (cls == C_STORE);
      end
      S_WB: begin
        reg_we    = reg_we_lat;
        pc_enable = 1'b1;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  // Instruction-class latch, wait counter, sticky traps and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls         <= C_ALU;
      reg_we_lat  <= 1'b0;
      ram_we_lat  <= 1'b0;
      br_en_lat   <= 1'b0;
      wait_cnt    <= '0;
      illegal_r   <= 1'b0;
      timeout_r   <= 1'b0;
      retired_cnt <= '0;
    end else begin
      if (cur_state == S_DECODE) begin
        cls        <= op_info[1:0];
        reg_we_lat <= dec_reg_we;
        ram_we_lat <= dec_ram_we;
        br_en_lat  <= dec_br_en;
      end
      if (nxt_state != cur_state) begin
        wait_cnt <= '0;
      end else if (((cur_state == S_FETCH) && !imem_ready) ||
                   ((cur_state == S_MEM) && !dmem_ready)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if ((cur_state == S_DECODE) && !op_info[2]) begin
        illegal_r <= 1'b1;
      end
      if (fetch_expire || mem_expire) begin
        timeout_r <= 1'b1;
      end
      if (pc_enable) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end

endmodule
